rename_reg_file: RTL and testbench
==================================

Name: rename_reg_file

Overview:
- Architectural register file with per-register rename state (busy bit plus ROB tag); it is the responder end of the ROB commit-to-register interface.
- Issue side: renames a destination register to a ROB index and reads source operands, returning either a value or a pending tag.
- Commit side: answers the ROB's busy/tag query for the committing rd, then accepts the committed value and the conditional busy clear.
- Flush: global clear drops all pending renames.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; x0 is hard-wired to zero.
- TAG_W, 5, ROB index width (32-entry ROB).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes all state
- clear_flag  in  1  pipeline flush
- rs1  in  5  issue source 1 index
- rs2  in  5  issue source 2 index
- rs1_value  out  XLEN  register value
- rs1_busy  out  1  rs1 awaits a ROB result
- rs1_tag  out  TAG_W  producing ROB index for rs1
- rs2_value  out  XLEN  register value
- rs2_busy  out  1  rs2 awaits a ROB result
- rs2_tag  out  TAG_W  producing ROB index for rs2
- rename_en  in  1  issue renames rename_rd this cycle
- rename_rd  in  5  destination being renamed
- rename_tag  in  TAG_W  ROB index allocated to rename_rd
- commit_rd  in  5  ROB commit destination (also the query address)
- commit_busy  out  1  busy bit of commit_rd (combinational)
- commit_tag  out  TAG_W  tag of commit_rd (combinational)
- commit_en  in  1  write commit_value into commit_rd
- commit_value  in  XLEN  committed result
- commit_clr_busy  in  1  clear busy of commit_rd (ROB asserts it only when commit_busy is set and commit_tag equals the committing index)

Behaviour:
- Reset (rst_n low, async): all values 0, all busy 0, all tags 0. Outputs derive from state, so every busy/tag/value output reads 0 during reset.
- Read ports are combinational with zero latency. Index 0 always returns value 0, busy 0, tag 0.
- State updates occur on the rising clk edge only when rdy=1. With rdy=0 all state holds; read outputs still track inputs.
- Commit write: when commit_en=1 and commit_rd≠0, value[commit_rd] ← commit_value.
- Busy clear: when commit_en=1 and commit_clr_busy=1 and commit_rd≠0, busy[commit_rd] ← 0. Tag is left unchanged.
- Rename: when rename_en=1, rename_rd≠0 and clear_flag=0, busy[rename_rd] ← 1 and tag[rename_rd] ← rename_tag.
- Rename and busy-clear to the same rd in the same cycle: rename wins (busy=1, new tag). The value write still occurs.
- Flush: when clear_flag=1, every busy bit ← 0 and rename is ignored. A commit value write in the same cycle is still applied, because a JALR commit asserts flush and rd write together.
- Writes to x0 are dropped on all paths.
- Commit and rename to different rd in the same cycle are independent.
- rs1 and rs2 may equal each other and may equal rename_rd. Reads return pre-edge state; no rename bypass.

Optional Feature:
- COMMIT_BYPASS_EN defined: when commit_en=1 and rsN equals a nonzero commit_rd, rsN_value = commit_value.
  - If in addition commit_clr_busy=1, rsN_busy reads 0.
  - This lets issue capture a result committed in the same cycle.
- Undefined: read ports return registered state only; the committed value becomes visible the cycle after commit.

Test Plan:
- Reset check: assert rst_n=0 mid-run after x5 has been renamed; release; read rs1=5 -> value 0, busy 0, tag 0.
- Rename then commit: rename x5 tag 7; next cycle rs1=5 -> busy 1, tag 7. Commit x5 value 0xDEADBEEF with clr_busy -> next cycle busy 0, value 0xDEADBEEF.
- Stale commit:
  - rename x3 tag 2, then rename x3 tag 9.
  - Query commit_rd=3 -> commit_busy 1, commit_tag 9.
  - Commit x3 value 0x11 with clr_busy=0 -> value 0x11, busy 1, tag 9.
- Collision: same cycle, rename x4 tag 12 and commit x4 value 0x22 with clr_busy=1 -> value 0x22, busy 1, tag 12.
- Flush with JALR: x1 and x2 busy; same cycle clear_flag=1 and commit x1 value 0x1004 with clr_busy=1 -> all busy 0, x1 = 0x1004. A simultaneous rename of x6 is ignored, so x6 busy 0.
- x0 and rdy:
  - Commit x0 value 0xFFFF and rename x0 -> rs1=0 reads 0, busy 0.
  - With rdy=0, a commit of x8 value 5 leaves x8 unchanged.
  - With COMMIT_BYPASS_EN, same-cycle rs2=8 during a rdy=1 commit of value 5 shows value 5, busy 0.

Source files
------------

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Issue side reads two sources and renames one destination per cycle; commit
// side answers the ROB busy/tag query and accepts the committed value.
// Optional build macro: COMMIT_BYPASS_EN forwards a same-cycle commit onto the
// issue read ports (value, and busy cleared when commit_clr_busy is set).
module rename_reg_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             clear_flag,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [XLEN-1:0]  rs1_value,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_value,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic             rename_en,
    input  logic [4:0]       rename_rd,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic [4:0]       commit_rd,
    output logic             commit_busy,
    output logic [TAG_W-1:0] commit_tag,
    input  logic             commit_en,
    input  logic [XLEN-1:0]  commit_value,
    input  logic             commit_clr_busy
);

    localparam int unsigned IDX_W = 5;

    logic [XLEN-1:0]  value_q [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [NREG-1:0]  busy_q;

    logic [XLEN-1:0]  value_d [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];
    logic [NREG-1:0]  busy_d;

    logic commit_wr;
    logic commit_clr;
    logic rename_wr;

    // Qualified write strobes; x0 is never a write target.
    always_comb begin
        commit_wr  = commit_en && (commit_rd != IDX_W'(0));
        commit_clr = commit_wr && commit_clr_busy;
        rename_wr  = rename_en && (rename_rd != IDX_W'(0)) && !clear_flag;
    end

    // Next-state: commit value/clear first, then flush or rename override busy.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_wr) begin
            value_d[commit_rd] = commit_value;
        end
        if (commit_clr) begin
            busy_d[commit_rd] = 1'b0;
        end
        if (clear_flag) begin
            busy_d = '0;
        end else if (rename_wr) begin
            busy_d[rename_rd] = 1'b1;
            tag_d[rename_rd]  = rename_tag;
        end
    end

    // State register; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    // Source 1 read port; x0 reads as a ready zero.
    always_comb begin
        rs1_value = '0;
        rs1_busy  = 1'b0;
        rs1_tag   = '0;
        if (rs1 != IDX_W'(0)) begin
            rs1_value = value_q[rs1];
            rs1_busy  = busy_q[rs1];
            rs1_tag   = tag_q[rs1];
`ifdef COMMIT_BYPASS_EN
            if (commit_wr && (commit_rd == rs1)) begin
                rs1_value = commit_value;
                if (commit_clr_busy) begin
                    rs1_busy = 1'b0;
                end
            end
`endif
        end
    end

    // Source 2 read port; x0 reads as a ready zero.
    always_comb begin
        rs2_value = '0;
        rs2_busy  = 1'b0;
        rs2_tag   = '0;
        if (rs2 != IDX_W'(0)) begin
            rs2_value = value_q[rs2];
            rs2_busy  = busy_q[rs2];
            rs2_tag   = tag_q[rs2];
`ifdef COMMIT_BYPASS_EN
            if (commit_wr && (commit_rd == rs2)) begin
                rs2_value = commit_value;
                if (commit_clr_busy) begin
                    rs2_busy = 1'b0;
                end
            end
`endif
        end
    end

    // ROB commit query: current busy/tag of the committing destination.
    always_comb begin
        commit_busy = 1'b0;
        commit_tag  = '0;
        if (commit_rd != IDX_W'(0)) begin
            commit_busy = busy_q[commit_rd];
            commit_tag  = tag_q[commit_rd];
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file: stimulus pushes expected read results,
// a negedge monitor pops and compares them against the DUT ports.
module tb_rename_reg_file;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             rdy;
    logic             clear_flag;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  rs1_value;
    logic             rs1_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs2_value;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs2_tag;
    logic             rename_en;
    logic [4:0]       rename_rd;
    logic [TAG_W-1:0] rename_tag;
    logic [4:0]       commit_rd;
    logic             commit_busy;
    logic [TAG_W-1:0] commit_tag;
    logic             commit_en;
    logic [XLEN-1:0]  commit_value;
    logic             commit_clr_busy;

    rename_reg_file #(.XLEN(XLEN), .NREG(32), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear_flag(clear_flag),
        .rs1(rs1), .rs2(rs2),
        .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .commit_rd(commit_rd), .commit_busy(commit_busy), .commit_tag(commit_tag),
        .commit_en(commit_en), .commit_value(commit_value),
        .commit_clr_busy(commit_clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // port: 0 = rs1, 1 = rs2, 2 = commit query (value unused)
    typedef struct {
        string       name;
        int          port;
        logic [31:0] value;
        logic        busy;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: drain everything the stimulus queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            case (e.port)
                0: begin
                    cmp({e.name, ".rs1_value"}, rs1_value, e.value);
                    cmp({e.name, ".rs1_busy"}, 32'(rs1_busy), 32'(e.busy));
                    cmp({e.name, ".rs1_tag"}, 32'(rs1_tag), 32'(e.tag));
                end
                1: begin
                    cmp({e.name, ".rs2_value"}, rs2_value, e.value);
                    cmp({e.name, ".rs2_busy"}, 32'(rs2_busy), 32'(e.busy));
                    cmp({e.name, ".rs2_tag"}, 32'(rs2_tag), 32'(e.tag));
                end
                default: begin
                    cmp({e.name, ".commit_busy"}, 32'(commit_busy), 32'(e.busy));
                    cmp({e.name, ".commit_tag"}, 32'(commit_tag), 32'(e.tag));
                end
            endcase
        end
    end

    // Advance one cycle and return all controls to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        rdy             = 1'b1;
        clear_flag      = 1'b0;
        rename_en       = 1'b0;
        rename_rd       = 5'd0;
        rename_tag      = 5'd0;
        commit_en       = 1'b0;
        commit_rd       = 5'd0;
        commit_value    = 32'd0;
        commit_clr_busy = 1'b0;
        rs1             = 5'd0;
        rs2             = 5'd0;
    endtask

    task automatic exp_rd(input int port, input logic [4:0] idx, input logic [31:0] v,
                          input logic b, input logic [4:0] t, input string nm);
        exp_t e;
        if (port == 0) rs1 = idx; else rs2 = idx;
        e.name = nm; e.port = port; e.value = v; e.busy = b; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic exp_cq(input logic [4:0] idx, input logic b, input logic [4:0] t,
                          input string nm);
        exp_t e;
        commit_rd = idx;
        e.name = nm; e.port = 2; e.value = 32'd0; e.busy = b; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] t);
        rename_en = 1'b1; rename_rd = rd; rename_tag = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic clr);
        commit_en = 1'b1; commit_rd = rd; commit_value = v; commit_clr_busy = clr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; clear_flag = 1'b0;
        rename_en = 1'b0; rename_rd = 5'd0; rename_tag = 5'd0;
        commit_en = 1'b0; commit_rd = 5'd0; commit_value = 32'd0; commit_clr_busy = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0;

        cyc(); exp_rd(0, 5'd5, 32'd0, 1'b0, 5'd0, "por");
        cyc(); rst_n = 1'b1;
        rename(5'd5, 5'd7); exp_rd(0, 5'd5, 32'd0, 1'b0, 5'd0, "no_bypass_rename");
        cyc(); exp_rd(0, 5'd5, 32'd0, 1'b1, 5'd7, "renamed_x5");
        cyc(); commit(5'd5, 32'hDEADBEEF, 1'b1); exp_cq(5'd5, 1'b1, 5'd7, "query_x5");
        cyc(); exp_rd(0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, "committed_x5");
        cyc(); rename(5'd5, 5'd3);
        cyc(); exp_rd(1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd3, "rerenamed_x5");
        // Asynchronous reset mid-cycle, then release.
        cyc(); rst_n = 1'b0; #1; exp_rd(0, 5'd5, 32'd0, 1'b0, 5'd0, "in_reset");
        cyc(); rst_n = 1'b1; exp_rd(1, 5'd5, 32'd0, 1'b0, 5'd0, "post_reset");

        // Stale commit keeps the newer rename.
        cyc(); rename(5'd3, 5'd2);
        cyc(); rename(5'd3, 5'd9);
        cyc(); exp_cq(5'd3, 1'b1, 5'd9, "query_x3");
        cyc(); commit(5'd3, 32'h11, 1'b0);
        cyc(); exp_rd(0, 5'd3, 32'h11, 1'b1, 5'd9, "stale_x3");

        // Rename and busy-clear to the same rd: rename wins.
        cyc(); rename(5'd4, 5'd12); commit(5'd4, 32'h22, 1'b1);
        cyc(); exp_rd(0, 5'd4, 32'h22, 1'b1, 5'd12, "collide_x4");

        // Flush with JALR commit and an ignored rename.
        cyc(); rename(5'd1, 5'd1);
        cyc(); rename(5'd2, 5'd2);
        cyc(); exp_rd(0, 5'd1, 32'd0, 1'b1, 5'd1, "pre_flush_x1");
               exp_rd(1, 5'd2, 32'd0, 1'b1, 5'd2, "pre_flush_x2");
        cyc(); clear_flag = 1'b1; commit(5'd1, 32'h1004, 1'b1); rename(5'd6, 5'd5);
        cyc(); exp_rd(0, 5'd1, 32'h1004, 1'b0, 5'd1, "flush_x1");
               exp_rd(1, 5'd2, 32'd0, 1'b0, 5'd2, "flush_x2");
        cyc(); exp_rd(0, 5'd6, 32'd0, 1'b0, 5'd0, "flush_x6");
               exp_rd(1, 5'd4, 32'h22, 1'b0, 5'd12, "flush_x4");
        cyc(); exp_rd(0, 5'd3, 32'h11, 1'b0, 5'd9, "flush_x3");

        // x0 writes are dropped on every path.
        cyc(); commit(5'd0, 32'hFFFF, 1'b1); rename(5'd0, 5'd7);
               exp_cq(5'd0, 1'b0, 5'd0, "query_x0");
               exp_rd(0, 5'd0, 32'd0, 1'b0, 5'd0, "x0_same_cycle");
        cyc(); exp_rd(0, 5'd0, 32'd0, 1'b0, 5'd0, "x0_after");

        // rdy low freezes state.
        cyc(); rdy = 1'b0; commit(5'd8, 32'd5, 1'b1); rename(5'd9, 5'd4);
        cyc(); exp_rd(0, 5'd8, 32'd0, 1'b0, 5'd0, "rdy_low_x8");
               exp_rd(1, 5'd9, 32'd0, 1'b0, 5'd0, "rdy_low_x9");

        // Same-cycle commit visible on the read port only with bypass.
        cyc(); rename(5'd8, 5'd6);
        cyc(); commit(5'd8, 32'd5, 1'b1);
               exp_rd(1, 5'd8, BYP ? 32'd5 : 32'd0, !BYP, 5'd6, "bypass_x8");
        cyc(); exp_rd(0, 5'd8, 32'd5, 1'b0, 5'd6, "commit_x8_rs1");
               exp_rd(1, 5'd8, 32'd5, 1'b0, 5'd6, "commit_x8_rs2");

        cyc(); cyc();
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
